meta_merge_arbiter: RTL

META_MERGE_ARBITER -- requirements
Module: meta_merge_arbiter

---
 rtl/struct_s.sv | 20 ++
 rtl/meta_sync_fifo.sv | 55 +++++
 rtl/meta_merge_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/struct_s.sv
// Shared metadata types and input-port indices for the metadata merge path.
package struct_s;

   typedef struct packed {
      logic [7:0]  tag;
      logic [15:0] len;
      logic [3:0]  flags;
      logic [3:0]  qid;
   } metadata_t;

   localparam int N_IN      = 3;
   localparam int IDX_OUT   = 0;
   localparam int IDX_FWD   = 1;
   localparam int IDX_REORD = 2;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

endpackage

// File: rtl/meta_sync_fifo.sv
// Single-clock FIFO with registered head; storage itself is never reset.
module meta_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == CW'(DEPTH));
   assign count    = r_count;
   assign pop_data = r_mem[r_rd];
   assign w_push   = push & ~full;
   assign w_pop    = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= push_data;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/meta_merge_arbiter.sv
// Round-robin merge of three metadata streams into one buffered output,
// with per-port accepted-beat statistics.
module meta_merge_arbiter
   import struct_s::*;
#(
   parameter int DATA_W    = $bits(metadata_t),
   parameter int OUT_DEPTH = 4,
   parameter int AF_LEVEL  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_IN-1:0][DATA_W-1:0]  in_data,
   input  logic [N_IN-1:0]              in_valid,
   output logic [N_IN-1:0]              in_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_almost_full,
   output logic [N_IN-1:0][31:0]        stats_in,
   output logic [31:0]                  stats_out
);

   localparam int CW = $clog2(OUT_DEPTH) + 1;

   logic [1:0]              r_rr_ptr;
   logic                    r_af;
   logic [N_IN-1:0][31:0]   r_stats_in;
   logic [31:0]             r_stats_out;

   logic [N_IN-1:0]         w_grant;
   logic [1:0]              w_gidx;
   logic [1:0]              w_idx;
   logic                    w_any;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [CW-1:0]           w_count;
   logic [CW-1:0]           w_cnt_next;
   logic [DATA_W-1:0]       w_push_data;

   // first valid input at or after rr_ptr wins
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_idx   = '0;
      w_any   = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         w_idx = wrap3({1'b0, r_rr_ptr} + 3'(k));
         if (!w_any && in_valid[w_idx]) begin
            w_grant[w_idx] = 1'b1;
            w_gidx         = w_idx;
            w_any          = 1'b1;
         end
      end
   end

   assign in_ready    = w_grant & {N_IN{~w_full & ~rst}};
   assign w_push      = |(in_valid & in_ready);
   assign w_pop       = out_valid & out_ready;
   assign w_push_data = in_data[w_gidx];
   assign out_valid   = ~w_empty;
   assign w_cnt_next  = w_count + CW'(w_push) - CW'(w_pop);

   assign out_almost_full = r_af;
   assign stats_in        = r_stats_in;
   assign stats_out       = r_stats_out;

   meta_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (OUT_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .pop_data  (out_data),
      .count     (w_count),
      .empty     (w_empty),
      .full      (w_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_af        <= 1'b0;
         r_stats_in  <= '0;
         r_stats_out <= '0;
      end else begin
         if (w_push) r_rr_ptr <= wrap3({1'b0, w_gidx} + 3'd1);
         r_af <= (32'(w_cnt_next) >= AF_LEVEL);
         for (int i = 0; i < N_IN; i++) begin
            if (in_valid[i] && in_ready[i])
               r_stats_in[i] <= r_stats_in[i] + 32'd1;
         end
         if (w_pop) r_stats_out <= r_stats_out + 32'd1;
      end
   end

endmodule
